// File: rtl/inst_buffer_pkg.sv
// Shared sizing for the fetch/decode instruction buffer.
// Fetch and dispatch size their logic against IB_DEPTH.
// Word widths and the decoder idle instruction live here too.
package inst_buffer_pkg;

  // Default buffer depth; must be a power of two and at least 2.
  localparam int IB_DEPTH = 8;

  // Instruction word and address widths.
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  // Canonical no-op (addi x0, x0, 0) presented to decode when idle.
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/inst_buffer.sv
// Purpose: circular instruction buffer between fetch and the decoder, squashable in one cycle.
// Latency: 1 cycle from a push into an empty buffer to the head outputs (no fall-through).
// Backpressure: ib_ready = !full from registered state; a push while full is refused even with a pop.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic                       if_valid,
  input  logic [INST_W-1:0]          if_inst,
  input  logic [ADDR_W-1:0]          if_pc,
  output logic                       ib_ready,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [INST_W-1:0]          id_inst,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d   [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Flags and handshakes come only from registered occupancy, so ib_ready
  // has no combinational dependence on if_valid or id_ready.
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    push  = if_valid && !full;
    pop   = !empty && id_ready;
  end

  // Next-state for pointers, occupancy and storage; squash overrides push/pop.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        inst_mem_d[tail_q] = if_inst;
        pc_mem_d[tail_q]   = if_pc;
        tail_d             = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset empties the buffer immediately and zeroes storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  // Head outputs read straight from storage; idle values shown when empty.
  always_comb begin
    ib_ready = !full;
    id_valid = !empty;
    count    = count_q;
    id_inst  = empty ? NOP : inst_mem_q[head_q];
    id_pc    = empty ? '0  : pc_mem_q[head_q];
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: directed stimulus with a queue scoreboard
// checked at every falling edge, plus hand-computed spot checks at test-plan points.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic        clock;
  logic        reset;
  logic        squash;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        ib_ready;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q [$];

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .squash   (squash),
    .if_valid (if_valid),
    .if_inst  (if_inst),
    .if_pc    (if_pc),
    .ib_ready (ib_ready),
    .id_ready (id_ready),
    .id_valid (id_valid),
    .id_inst  (id_inst),
    .id_pc    (id_pc),
    .count    (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: inputs and outputs are stable at the falling edge. Compare the
  // visible state with the model, then apply what the next rising edge will do.
  always @(negedge clock) begin
    bit acc;
    if (reset) exp_q.delete();
    check("sb_count", 64'(count), 64'(exp_q.size()));
    check("sb_ib_ready", 64'(ib_ready), 64'(exp_q.size() != DEPTH));
    check("sb_id_valid", 64'(id_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("sb_head", {id_inst, id_pc}, exp_q[0]);
    else
      check("sb_idle_out", {id_inst, id_pc}, {32'h0000_0013, 32'h0});
    if (!reset) begin
      if (squash) begin
        exp_q.delete();
      end else begin
        acc = if_valid && (exp_q.size() != DEPTH);
        if (id_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({if_inst, if_pc});
      end
    end
  end

  // Apply one cycle of inputs and return just after the rising edge.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic sq);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
    id_ready = rdy;
    squash   = sq;
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && id_valid; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drain_empty", 64'(id_valid), 64'(0));
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; id_ready = 1'b0;
    #1;
    check("rst_ib_ready", 64'(ib_ready), 64'(1));
    check("rst_id_valid", 64'(id_valid), 64'(0));
    check("rst_id_inst", 64'(id_inst), 64'(32'h0000_0013));
    check("rst_count", 64'(count), 64'(0));
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Fill and drain
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h1000_0000 | 32'(i), 32'(i * 4), 1'b0, 1'b0);
    check("fill_count", 64'(count), 64'(8));
    check("fill_ib_ready", 64'(ib_ready), 64'(0));
    check("fill_head_pc", 64'(id_pc), 64'(32'h0));

    // Full with simultaneous pop: push refused, one pop
    drive(1'b1, 32'h1000_0008, 32'h20, 1'b1, 1'b0);
    check("fullpop_count", 64'(count), 64'(7));
    check("fullpop_head_pc", 64'(id_pc), 64'(32'h4));
    drive(1'b1, 32'h1000_0008, 32'h20, 1'b1, 1'b0);
    check("fullpop2_count", 64'(count), 64'(7));
    check("fullpop2_head_pc", 64'(id_pc), 64'(32'h8));
    drain();
    check("drain_count", 64'(count), 64'(0));

    // Streaming wrap at count=1
    drive(1'b1, 32'h2000_0000, 32'h100, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) drive(1'b1, 32'h2000_0000 | 32'(i), 32'h100 + 32'(i * 4), 1'b1, 1'b0);
    check("stream_count", 64'(count), 64'(1));
    check("stream_head_pc", 64'(id_pc), 64'(32'h150));
    drain();

    // Squash at count=5 together with a push
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h3000_0000 | 32'(i), 32'h200 + 32'(i * 4), 1'b0, 1'b0);
    check("sq_pre_count", 64'(count), 64'(5));
    drive(1'b1, 32'hDEAD_0000, 32'h300, 1'b0, 1'b1);
    check("sq_count", 64'(count), 64'(0));
    check("sq_id_valid", 64'(id_valid), 64'(0));
    check("sq_id_inst", 64'(id_inst), 64'(32'h0000_0013));
    check("sq_ib_ready", 64'(ib_ready), 64'(1));
    drive(1'b1, 32'h2222_2222, 32'h304, 1'b0, 1'b0);
    check("sq_next_count", 64'(count), 64'(1));
    check("sq_next_pc", 64'(id_pc), 64'(32'h304));
    drain();

    // Async reset mid-operation at count=3
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h4000_0000 | 32'(i), 32'h400 + 32'(i * 4), 1'b0, 1'b0);
    check("ar_pre_count", 64'(count), 64'(3));
    if_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("ar_id_valid", 64'(id_valid), 64'(0));
    check("ar_count", 64'(count), 64'(0));
    check("ar_ib_ready", 64'(ib_ready), 64'(1));
    check("ar_id_pc", 64'(id_pc), 64'(0));
    @(posedge clock);
    #1 reset = 1'b0;

    // Empty push latency right after reset release
    if_valid = 1'b1; if_inst = 32'h00A0_0093; if_pc = 32'h40; id_ready = 1'b0; squash = 1'b0;
    #1;
    check("lat_push_cycle_valid", 64'(id_valid), 64'(0));
    @(posedge clock);
    #1;
    if_valid = 1'b0;
    check("lat_valid", 64'(id_valid), 64'(1));
    check("lat_inst", 64'(id_inst), 64'(32'h00A0_0093));
    check("lat_pc", 64'(id_pc), 64'(32'h40));
    drain();

    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
